// File: rtl/fetch_unit_if.sv
// Instruction-memory channel between the fetch stage and instruction memory.
//   imem_req_valid / imem_req_ready / imem_addr : word request, valid/ready handshake
//   imem_rsp_valid / imem_rsp_data              : response, valid only (no backpressure)
// master modport: fetch side, slave modport: memory side.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one word request at a time to
// instruction memory and hands {instruction, pc} to decode through the IF/ID
// register, with a one-entry skid buffer for responses that land during a stall.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   imem (master)       : request/response channel to instruction memory
//   redirect_valid/_pc  : flush and refetch from redirect_pc (low two bits ignored)
//   stall               : decode cannot accept, IF/ID holds
//   id_valid/_instruction/_pc : IF/ID register contents
//   perf_fetched/_flushed     : event counters, present only with FETCH_PERF_CNT_EN
// Optional feature macro: FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  fetch_unit_if.master    imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instruction,
  output logic [XLEN-1:0] id_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  // Skid buffer occupancy is implied by state HOLD, so it carries no valid bit.
  logic [XLEN-1:0] skid_data_q, skid_data_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            req_valid_q;
  logic            can_accept;
  logic            rsp;

  assign can_accept = !id_valid_q || !stall;
  assign rsp        = imem.imem_rsp_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_REQ;
    else     state_q <= state_d;
  end

  // Next-state logic; redirect outranks every other event
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      case (state_q)
        S_REQ:   state_d = imem.imem_req_ready ? S_DROP : S_REQ;
        S_WAIT:  state_d = rsp ? S_REQ : S_DROP;
        S_HOLD:  state_d = S_REQ;
        default: state_d = rsp ? S_REQ : S_DROP;
      endcase
    end else begin
      case (state_q)
        S_REQ:   if (imem.imem_req_ready) state_d = S_WAIT;
        S_WAIT:  if (rsp) state_d = can_accept ? S_REQ : S_HOLD;
        S_HOLD:  if (!stall) state_d = S_REQ;
        default: if (rsp) state_d = S_REQ;
      endcase
    end
  end

  // Datapath next values: PC, IF/ID register and skid buffer
  always_comb begin
    pc_d        = pc_q;
    id_valid_d  = id_valid_q && stall;  // drops once consumed unless reloaded below
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    if (redirect_valid) begin
      pc_d        = redirect_pc & ~XLEN'(3);
      id_valid_d  = 1'b0;
      skid_data_d = '0;
      skid_pc_d   = '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (rsp) begin
            pc_d = pc_q + XLEN'(4);
            if (can_accept) begin
              id_valid_d = 1'b1;
              id_instr_d = imem.imem_rsp_data;
              id_pc_d    = pc_q;
            end else begin
              skid_data_d = imem.imem_rsp_data;
              skid_pc_d   = pc_q;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            id_valid_d = 1'b1;
            id_instr_d = skid_data_q;
            id_pc_d    = skid_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      id_valid_q  <= 1'b0;
      id_instr_q  <= NOP;
      id_pc_q     <= '0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
      req_valid_q <= 1'b1;
    end else begin
      pc_q        <= pc_d;
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      req_valid_q <= (state_d == S_REQ);
    end
  end

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_addr      = pc_q;
  assign id_valid            = id_valid_q;
  assign id_instruction      = id_instr_q;
  assign id_pc               = id_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_flushed_q;

  // A load into IF/ID is a valid next value while the register is not holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (id_valid_d && can_accept) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (redirect_valid && (id_valid_q || state_q == S_WAIT || state_q == S_HOLD))
        perf_flushed_q <= perf_flushed_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table for the basic
// fetch stream, hand sequences for stall/redirect/reset corners, and a
// scoreboard fed by a behavioural memory for a randomised run.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic        redirect2_valid;
  logic [31:0] redirect2_pc;
  logic        stall2;
  logic        id2_valid;
  logic [31:0] id2_instruction;
  logic [31:0] id2_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed, perf2_fetched, perf2_flushed;
`endif

  fetch_unit_if #(.XLEN(32)) bus ();
  fetch_unit_if #(.XLEN(32)) bus2 ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem(bus),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .id_valid(id_valid), .id_instruction(id_instruction), .id_pc(id_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .imem(bus2),
    .redirect_valid(redirect2_valid), .redirect_pc(redirect2_pc), .stall(stall2),
    .id_valid(id2_valid), .id_instruction(id2_instruction), .id_pc(id2_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf2_fetched), .perf_flushed(perf2_flushed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic        ready;
    logic        stall;
    logic        exp_req_valid;
    logic [31:0] exp_addr;
    logic        exp_id_valid;
    logic [31:0] exp_id_pc;
    logic [31:0] exp_id_instr;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  exp_t        sb_q[$];
  logic [31:0] addr2_q[$];
  logic [31:0] exp_pc;
  logic        inflight, dead;
  logic        m_pend;
  int          m_cnt;
  logic [31:0] m_addr;
  int          lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      default: return a ^ 32'h5A5A_0013;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // One clock: scoreboard/model on pre-edge values, then memory response update.
  task automatic cycle();
    logic acc, rspv, redir, cons, acc2;
    logic [31:0] a2;
    exp_t e;
    acc   = bus.imem_req_valid && bus.imem_req_ready && !rst;
    rspv  = bus.imem_rsp_valid && !rst;
    redir = redirect_valid && !rst;
    cons  = id_valid && !stall && !redir && !rst;
    acc2  = bus2.imem_req_valid && bus2.imem_req_ready && !rst;
    a2    = bus2.imem_addr;
    if (cons) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected actual_pc=%h expected=none", id_pc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pc", id_pc, e.pc);
        chk("sb_instr", id_instruction, e.instr);
        pops++;
      end
    end
    if (acc) chk("req_addr", bus.imem_addr, exp_pc);
    if (rspv) begin
      if (inflight && !dead && !redir) begin
        e.pc = exp_pc; e.instr = mem_word(exp_pc);
        sb_q.push_back(e);
        exp_pc = exp_pc + 32'd4;
      end
      inflight = 1'b0; dead = 1'b0;
    end
    if (acc) begin inflight = 1'b1; dead = 1'b0; end
    if (redir) begin
      sb_q.delete();
      exp_pc = redirect_pc & ~32'd3;
      if (inflight) dead = 1'b1;
    end
    if (rst) begin
      sb_q.delete();
      exp_pc = 32'h0;
      if (inflight) dead = 1'b1;
    end
    if (acc) begin m_pend = 1'b1; m_cnt = lat; m_addr = bus.imem_addr; end
    @(posedge clk);
    #1;
    bus.imem_rsp_valid = 1'b0;
    if (m_pend) begin
      if (m_cnt <= 1) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(m_addr);
        m_pend = 1'b0;
      end else m_cnt--;
    end
    bus2.imem_rsp_valid = acc2;
    bus2.imem_rsp_data  = mem_word(a2);
    if (acc2 && addr2_q.size() < 2) addr2_q.push_back(a2);
  endtask

  task automatic chk_out(input string nm, input logic rv, input logic [31:0] ad,
                         input logic iv, input logic [31:0] ip);
    chk({nm, "_req_valid"}, 32'(bus.imem_req_valid), 32'(rv));
    chk({nm, "_addr"}, bus.imem_addr, ad);
    chk({nm, "_id_valid"}, 32'(id_valid), 32'(iv));
    if (iv) chk({nm, "_id_pc"}, id_pc, ip);
  endtask

  vec_t vecs[4];

  initial begin
    logic done;
    int   n;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 32'h0, 32'h0050_0093};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h8, 1'b1, 32'h4, 32'h00A0_0113};

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    stall2 = 1'b0; redirect2_valid = 1'b0; redirect2_pc = '0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus2.imem_req_ready = 1'b1; bus2.imem_rsp_valid = 1'b0; bus2.imem_rsp_data = '0;
    exp_pc = '0; inflight = 1'b0; dead = 1'b0; m_pend = 1'b0; m_cnt = 0; m_addr = '0; lat = 1;
    #1;
    repeat (3) cycle();

    // Reset values
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instruction, 32'h0000_0013);
    chk("rst_id_pc", id_pc, 32'h0);
    rst = 1'b0;

    // Basic stream, always-ready 1-cycle memory
    for (int i = 0; i < 4; i++) begin
      bus.imem_req_ready = vecs[i].ready;
      stall = vecs[i].stall;
      cycle();
      chk($sformatf("vec%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(vecs[i].exp_req_valid));
      chk($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_id_valid", i), 32'(id_valid), 32'(vecs[i].exp_id_valid));
      if (vecs[i].exp_id_valid) begin
        chk($sformatf("vec%0d_id_pc", i), id_pc, vecs[i].exp_id_pc);
        chk($sformatf("vec%0d_id_instr", i), id_instruction, vecs[i].exp_id_instr);
      end
    end

    // Stall for 3 cycles while a response lands: IF/ID holds, word goes to skid
    stall = 1'b1;
    cycle(); chk_out("stall1", 1'b0, 32'h8, 1'b1, 32'h4);
    cycle(); chk_out("stall2", 1'b0, 32'hC, 1'b1, 32'h4);
    cycle(); chk_out("stall3", 1'b0, 32'hC, 1'b1, 32'h4);
    stall = 1'b0;
    cycle(); chk_out("unstall", 1'b1, 32'hC, 1'b1, 32'h8);
    chk("unstall_instr", id_instruction, mem_word(32'h8));

    // Redirect to 0x103 during WAIT, response two cycles later is dropped
    lat = 3;
    cycle(); chk_out("rd_wait", 1'b0, 32'hC, 1'b0, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h103; lat = 1;
    cycle(); chk_out("rd_drop", 1'b0, 32'h100, 1'b0, 32'h0);
    redirect_valid = 1'b0;
    cycle(); chk_out("rd_drop2", 1'b0, 32'h100, 1'b0, 32'h0);
    cycle(); chk_out("rd_req", 1'b1, 32'h100, 1'b0, 32'h0);
    cycle(); chk_out("rd_wait2", 1'b0, 32'h100, 1'b0, 32'h0);
    cycle(); chk_out("rd_load", 1'b1, 32'h104, 1'b1, 32'h100);

    // Redirect in the same cycle as the response
    cycle();
    chk("same_rsp_seen", 32'(bus.imem_rsp_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cycle(); chk_out("same_req", 1'b1, 32'h200, 1'b0, 32'h0);
    redirect_valid = 1'b0;
    cycle();
    cycle(); chk_out("same_load", 1'b1, 32'h204, 1'b1, 32'h200);

    // Reset mid-transaction; the late response lands in REQ and is ignored
    lat = 3;
    cycle();
    rst = 1'b1; bus.imem_req_ready = 1'b0;
    cycle();
    rst = 1'b0;
    cycle(); chk_out("mid_rst", 1'b1, 32'h0, 1'b0, 32'h0);
    chk("late_rsp_seen", 32'(bus.imem_rsp_valid), 32'd1);
    cycle(); chk_out("late_rsp", 1'b1, 32'h0, 1'b0, 32'h0);

    // Randomised traffic against the scoreboard
    for (int i = 0; i < 800; i++) begin
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 9) < 3);
      lat = int'($urandom_range(1, 3));
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc = $urandom;
      cycle();
    end
    redirect_valid = 1'b0; stall = 1'b0;
    chk("sb_progress", 32'(pops > 60), 32'd1);

    // RESET_PC at the top of the address space wraps to zero
    chk("wrap_count", 32'(addr2_q.size()), 32'd2);
    if (addr2_q.size() >= 2) begin
      chk("wrap_first", addr2_q[0], 32'hFFFF_FFFC);
      chk("wrap_second", addr2_q[1], 32'h0000_0000);
    end

`ifdef FETCH_PERF_CNT_EN
    // 5 fetches, then one redirect while id_valid is high
    bus.imem_req_ready = 1'b0; rst = 1'b1;
    repeat (4) cycle();
    rst = 1'b0; bus.imem_req_ready = 1'b1; lat = 1;
    n = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      cycle();
      if (id_valid) n++;
      if (n == 5) begin
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cycle();
        redirect_valid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL perf_timeout actual_loads=%0d expected=5", n);
    end
    chk("perf_fetched", perf_fetched, 32'd5);
    chk("perf_flushed", perf_flushed, 32'd1);
`else
    done = 1'b0; n = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel, accepting responses on a valid-only channel.
- Delivers {instruction, pc} to decode through an IF/ID output register with stall and redirect (flush) support.
- At most one memory request is outstanding at any time.

Parameters:
- XLEN, 32: width of PC and instruction word.
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  request to instruction memory is valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  XLEN  word address of the request; bits [1:0] always 0.
- imem_rsp_valid  in  1  response data valid; one response per accepted request, any latency of 1 cycle or more.
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  branch/jump/trap redirect; flush and refetch.
- redirect_pc  in  XLEN  new PC; bits [1:0] ignored and forced to 0.
- stall  in  1  decode cannot accept; hold the IF/ID register.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_instruction  out  XLEN  instruction to decode.
- id_pc  out  XLEN  PC of id_instruction.

Behaviour:
- Reset values: pc=RESET_PC, state=REQ, id_valid=0, id_instruction=32'h0000_0013 (NOP), id_pc=0, skid buffer empty.
- imem_req_valid is high only in state REQ. imem_addr=pc.
- The IF/ID register can accept new data when (!id_valid || !stall). When stall=1 and id_valid=1, id_* hold.
- id_valid clears on a cycle where the register is consumed (!stall) and no new data loads.
- States:
  - REQ: if imem_req_ready, go to WAIT.
  - WAIT: on imem_rsp_valid:
    - If IF/ID can accept: load id_instruction=rsp_data, id_pc=pc, id_valid=1; pc+=4; go to REQ.
    - Otherwise: store {data, pc} in the skid buffer; pc+=4; go to HOLD.
  - HOLD: when !stall, move the skid buffer into IF/ID (id_valid=1) and go to REQ.
  - DROP: on imem_rsp_valid, discard the data and go to REQ.
- Throughput: best case 1 instruction per 2 cycles (REQ, then WAIT with a 1-cycle memory).
- Response-to-id_valid latency: 1 cycle (registered).
- Redirect has priority over every other event in the same cycle:
  - pc=redirect_pc & ~3; id_valid=0; skid buffer cleared.
  - From REQ with imem_req_ready=1 (request accepted that same cycle): go to DROP.
  - From REQ with imem_req_ready=0: stay in REQ with the new pc; the old request is withdrawn, which is legal.
  - From WAIT with no response this cycle: go to DROP.
  - From WAIT with a response this cycle: discard the response, go to REQ.
  - From HOLD: go to REQ.
  - From DROP: stay in DROP if the response is still pending; if it arrives this cycle, go to REQ.
- A redirect during stall still flushes IF/ID.
- pc wraps modulo 2^XLEN (0xFFFF_FFFC+4 = 0).
- An imem_rsp_valid seen in REQ or HOLD is a protocol error: ignored; no state change.
- rst asserted mid-transaction returns to reset values. A late memory response after reset is ignored, because the state is REQ.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32 bits) and perf_flushed (32 bits); both reset to 0 and wrap on overflow.
  - perf_fetched increments on each load of IF/ID with a valid instruction.
  - perf_flushed increments on each redirect_valid cycle where id_valid=1 or state is WAIT/HOLD, i.e. work was discarded.
- Not defined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, memory always ready, 1-cycle response returning 0x00500093 then 0x00A00113 → imem_addr 0x0 then 0x4; id_valid pulses with id_pc=0x0/id_instruction=0x00500093, then id_pc=0x4/0x00A00113.
- stall=1 for 3 cycles while id_valid=1 and a response arrives → id_* unchanged; skid buffer holds the new word; after stall drops, the next id_pc=prev+4 with no loss or duplication.
- redirect_valid with redirect_pc=0x103 during WAIT, response arriving 2 cycles later → response discarded; next imem_addr=0x100; id_valid=0 until the 0x100 instruction arrives.
- Redirect and imem_rsp_valid in the same cycle → response dropped; next request at the redirect target.
- RESET_PC=0xFFFF_FFFC → first fetch 0xFFFF_FFFC, second 0x0000_0000.
- With FETCH_PERF_CNT_EN: 5 fetches plus 1 redirect while id_valid=1 → perf_fetched=5, perf_flushed=1.
